// File: rtl/debounce_sync.sv
// debounce_sync: conditions a bouncy asynchronous input (switch/button) into a
// clean level for a downstream flip-flop data input.
//
// A 2-flop synchroniser brings d_raw into the clk domain; a four-state FSM then
// requires STABLE_CYCLES consecutive synchronised samples of a new level before
// the clean output follows it. All outputs are registered.
//
// Ports:
//   clk     - system clock, all state updates on posedge
//   rst     - synchronous reset, active-high, priority over all other logic
//   d_raw   - asynchronous raw input, may bounce or glitch
//   d_clean - debounced level
//   rise    - one-cycle pulse on the cycle d_clean goes 0->1
//   fall    - one-cycle pulse on the cycle d_clean goes 1->0
//   busy    - high while a candidate level change is being qualified
module debounce_sync #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic d_raw,
   output logic d_clean,
   output logic rise,
   output logic fall,
   output logic busy
);

   typedef enum logic [1:0] {
      StStableLo,
      StChkHi,
      StStableHi,
      StChkLo
   } state_e;

   // Count value reached on the sample just before the new level is accepted.
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             sync1_q;
   logic             sync2_q;
   logic             d_clean_q;
   logic             rise_q;
   logic             fall_q;
   logic             busy_q;

   // Only the second synchroniser stage is allowed to influence the FSM.
   logic s;
   assign s = sync2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         cnt_q     <= '0;
         state_q   <= StStableLo;
         d_clean_q <= 1'b0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         sync1_q <= d_raw;
         sync2_q <= sync1_q;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;

         case (state_q)
            StStableLo: begin
               if (s) begin
                  state_q <= StChkHi;
                  cnt_q   <= CntOne;
                  busy_q  <= 1'b1;
               end else begin
                  cnt_q  <= '0;
                  busy_q <= 1'b0;
               end
            end

            StChkHi: begin
               if (!s) begin
                  // Bounce rejected: back to the old level, output untouched.
                  state_q <= StStableLo;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else if (cnt_q == CntLast) begin
                  state_q   <= StStableHi;
                  cnt_q     <= '0;
                  d_clean_q <= 1'b1;
                  rise_q    <= 1'b1;
                  busy_q    <= 1'b0;
               end else begin
                  cnt_q  <= cnt_q + CntOne;
                  busy_q <= 1'b1;
               end
            end

            StStableHi: begin
               if (!s) begin
                  state_q <= StChkLo;
                  cnt_q   <= CntOne;
                  busy_q  <= 1'b1;
               end else begin
                  cnt_q  <= '0;
                  busy_q <= 1'b0;
               end
            end

            StChkLo: begin
               if (s) begin
                  state_q <= StStableHi;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else if (cnt_q == CntLast) begin
                  state_q   <= StStableLo;
                  cnt_q     <= '0;
                  d_clean_q <= 1'b0;
                  fall_q    <= 1'b1;
                  busy_q    <= 1'b0;
               end else begin
                  cnt_q  <= cnt_q + CntOne;
                  busy_q <= 1'b1;
               end
            end

            default: begin
               state_q <= StStableLo;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign d_clean = d_clean_q;
   assign rise    = rise_q;
   assign fall    = fall_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync with STABLE_CYCLES=4. Posedges occur at
// t = 5 + 10k; inputs change 1 ns after an edge, outputs are sampled 1 ns after
// an edge. "tick i" is the i-th edge after an input change, so the edge that
// first samples a change is tick 1 and an accepted level shows after tick 6.
module tb_debounce_sync;

   logic clk;
   logic rst;
   logic d_raw;
   logic d_clean;
   logic rise;
   logic fall;
   logic busy;

   int checks;
   int errors;

   debounce_sync #(
      .STABLE_CYCLES(4),
      .CNT_W        (8)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .d_raw  (d_raw),
      .d_clean(d_clean),
      .rise   (rise),
      .fall   (fall),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset with d_raw high, then release and watch the rise 6 edges later.
   task automatic test_reset();
      logic exp_d, exp_r, exp_b;
      rst   = 1'b1;
      d_raw = 1'b1;
      tick();
      tick();
      checks += 4;
      if (d_clean !== 1'b0) begin errors++; $display("FAIL reset_d_clean got %b exp 0", d_clean); end
      if (rise !== 1'b0)    begin errors++; $display("FAIL reset_rise got %b exp 0", rise); end
      if (fall !== 1'b0)    begin errors++; $display("FAIL reset_fall got %b exp 0", fall); end
      if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      rst = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         tick();
         exp_d = (i >= 6);
         exp_r = (i == 6);
         exp_b = (i >= 3 && i <= 5);
         checks += 3;
         if (d_clean !== exp_d) begin
            errors++; $display("FAIL post_reset_d_clean tick %0d got %b exp %b", i, d_clean, exp_d);
         end
         if (rise !== exp_r) begin
            errors++; $display("FAIL post_reset_rise tick %0d got %b exp %b", i, rise, exp_r);
         end
         if (busy !== exp_b) begin
            errors++; $display("FAIL post_reset_busy tick %0d got %b exp %b", i, busy, exp_b);
         end
      end
   endtask

   // From a stable high level, drop d_raw and expect one fall pulse at tick 6.
   task automatic test_fall();
      logic exp_d, exp_f, exp_b;
      d_raw = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         tick();
         exp_d = (i < 6);
         exp_f = (i == 6);
         exp_b = (i >= 3 && i <= 5);
         checks += 4;
         if (d_clean !== exp_d) begin
            errors++; $display("FAIL fall_d_clean tick %0d got %b exp %b", i, d_clean, exp_d);
         end
         if (fall !== exp_f) begin
            errors++; $display("FAIL fall_pulse tick %0d got %b exp %b", i, fall, exp_f);
         end
         if (rise !== 1'b0) begin
            errors++; $display("FAIL fall_no_rise tick %0d got %b exp 0", i, rise);
         end
         if (busy !== exp_b) begin
            errors++; $display("FAIL fall_busy tick %0d got %b exp %b", i, busy, exp_b);
         end
      end
   endtask

   // Clean step from a stable low: busy from tick 3, d_clean/rise at tick 6.
   task automatic test_rising_step();
      logic exp_d, exp_r, exp_b;
      d_raw = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         exp_d = (i >= 6);
         exp_r = (i == 6);
         exp_b = (i >= 3 && i <= 5);
         checks += 4;
         if (d_clean !== exp_d) begin
            errors++; $display("FAIL step_d_clean tick %0d got %b exp %b", i, d_clean, exp_d);
         end
         if (rise !== exp_r) begin
            errors++; $display("FAIL step_rise tick %0d got %b exp %b", i, rise, exp_r);
         end
         if (fall !== 1'b0) begin
            errors++; $display("FAIL step_no_fall tick %0d got %b exp 0", i, fall);
         end
         if (busy !== exp_b) begin
            errors++; $display("FAIL step_busy tick %0d got %b exp %b", i, busy, exp_b);
         end
      end
   endtask

   // High pulses of 1..3 samples from a stable low are rejected.
   task automatic test_bounce_reject();
      logic exp_b;
      for (int k = 1; k <= 3; k++) begin
         d_raw = 1'b1;
         for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == k) d_raw = 1'b0;
            exp_b = (i >= 3 && i <= k + 2);
            checks += 3;
            if (d_clean !== 1'b0) begin
               errors++; $display("FAIL bounce%0d_d_clean tick %0d got %b exp 0", k, i, d_clean);
            end
            if (rise !== 1'b0) begin
               errors++; $display("FAIL bounce%0d_rise tick %0d got %b exp 0", k, i, rise);
            end
            if (busy !== exp_b) begin
               errors++; $display("FAIL bounce%0d_busy tick %0d got %b exp %b", k, i, busy, exp_b);
            end
         end
      end
   endtask

   // Exactly 4 high samples are accepted; the following low qualifies too.
   task automatic test_boundary_accept();
      logic exp_d, exp_r, exp_f, exp_b;
      d_raw = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (i == 4) d_raw = 1'b0;
         exp_d = (i >= 6 && i <= 9);
         exp_r = (i == 6);
         exp_f = (i == 10);
         exp_b = (i >= 3 && i <= 5) || (i >= 7 && i <= 9);
         checks += 4;
         if (d_clean !== exp_d) begin
            errors++; $display("FAIL boundary_d_clean tick %0d got %b exp %b", i, d_clean, exp_d);
         end
         if (rise !== exp_r) begin
            errors++; $display("FAIL boundary_rise tick %0d got %b exp %b", i, rise, exp_r);
         end
         if (fall !== exp_f) begin
            errors++; $display("FAIL boundary_fall tick %0d got %b exp %b", i, fall, exp_f);
         end
         if (busy !== exp_b) begin
            errors++; $display("FAIL boundary_busy tick %0d got %b exp %b", i, busy, exp_b);
         end
      end
   endtask

   // Reset on the edge where cnt==2 discards the partial count.
   task automatic test_reset_mid();
      logic exp_d, exp_r;
      d_raw = 1'b1;
      tick();
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      checks += 3;
      if (busy !== 1'b0)    begin errors++; $display("FAIL mid_rst_busy got %b exp 0", busy); end
      if (d_clean !== 1'b0) begin errors++; $display("FAIL mid_rst_d_clean got %b exp 0", d_clean); end
      if (rise !== 1'b0)    begin errors++; $display("FAIL mid_rst_rise got %b exp 0", rise); end
      rst = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         tick();
         exp_d = (i >= 6);
         exp_r = (i == 6);
         checks += 2;
         if (d_clean !== exp_d) begin
            errors++; $display("FAIL mid_rel_d_clean tick %0d got %b exp %b", i, d_clean, exp_d);
         end
         if (rise !== exp_r) begin
            errors++; $display("FAIL mid_rel_rise tick %0d got %b exp %b", i, rise, exp_r);
         end
      end
   endtask

   // While stable high, low bursts of 1..3 samples must not move the level.
   task automatic test_glitch_hold();
      for (int k = 1; k <= 3; k++) begin
         d_raw = 1'b0;
         for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == k) d_raw = 1'b1;
            checks += 2;
            if (d_clean !== 1'b1) begin
               errors++; $display("FAIL glitch%0d_d_clean tick %0d got %b exp 1", k, i, d_clean);
            end
            if (fall !== 1'b0) begin
               errors++; $display("FAIL glitch%0d_fall tick %0d got %b exp 0", k, i, fall);
            end
         end
      end
   endtask

   // Reset coinciding with the qualifying edge wins: no pulse, d_clean stays 0.
   task automatic test_rst_collide();
      d_raw = 1'b1;
      for (int i = 1; i <= 5; i++) tick();
      rst = 1'b1;
      tick();
      checks += 3;
      if (d_clean !== 1'b0) begin errors++; $display("FAIL collide_d_clean got %b exp 0", d_clean); end
      if (rise !== 1'b0)    begin errors++; $display("FAIL collide_rise got %b exp 0", rise); end
      if (busy !== 1'b0)    begin errors++; $display("FAIL collide_busy got %b exp 0", busy); end
      d_raw = 1'b0;
      tick();
      rst = 1'b0;
      for (int i = 1; i <= 4; i++) tick();
      checks += 1;
      if (d_clean !== 1'b0) begin errors++; $display("FAIL collide_after_d_clean got %b exp 0", d_clean); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      d_raw  = 1'b0;
      test_reset();
      test_fall();
      test_rising_step();
      test_fall();
      test_bounce_reject();
      test_boundary_accept();
      test_reset_mid();
      test_glitch_hold();
      test_fall();
      test_rst_collide();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Conditioning stage directly upstream of the dflipflop data input.
- Takes an asynchronous, bouncy raw input (switch or button) and synchronises it into the clk domain with a 2-flop synchroniser.
- Filters bounce with a counter-based FSM and drives a clean level, d_clean, into dflipflop.d.
- Also emits single-cycle rise/fall pulses for edge-triggered consumers.

Parameters:
- STABLE_CYCLES, 4: consecutive synchronised samples of the new level required before d_clean changes. Legal range 2..2^CNT_W-1.
- CNT_W, 8: width of the stability counter.

Ports:
- clk     input   1      system clock, all state updates on posedge.
- rst     input   1      synchronous reset, active-high.
- d_raw   input   1      asynchronous raw input, may bounce or glitch.
- d_clean output  1      debounced level; feeds dflipflop.d.
- rise    output  1      one-cycle pulse, asserted on the same cycle d_clean goes 0->1.
- fall    output  1      one-cycle pulse, asserted on the same cycle d_clean goes 1->0.
- busy    output  1      high while a candidate level change is being qualified (CHK_HI or CHK_LO).

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: on a posedge with rst=1, every register clears and takes effect the same edge, rst has priority over all other logic.
  - sync1=0, sync2=0, cnt=0, state=STABLE_LO.
  - d_clean=0, rise=0, fall=0, busy=0.
- Synchroniser: sync1<=d_raw, sync2<=sync1. The FSM uses only s=sync2. d_raw never reaches FSM logic directly.
- FSM states: STABLE_LO, CHK_HI, STABLE_HI, CHK_LO. All outputs are registered.
- STABLE_LO:
  - s=1: go to CHK_HI, cnt<=1.
  - else stay, cnt<=0.
- CHK_HI:
  - s=0: go to STABLE_LO, cnt<=0 (bounce rejected, no output change).
  - s=1 and cnt==STABLE_CYCLES-1: go to STABLE_HI, d_clean<=1, rise<=1, cnt<=0.
  - s=1 otherwise: cnt<=cnt+1.
- STABLE_HI / CHK_LO: mirror of STABLE_LO / CHK_HI with levels inverted. Qualification drives d_clean<=0 and fall<=1.
- rise and fall default to 0 every cycle. They are high for exactly one cycle, never simultaneously.
- busy is high exactly when the next state is CHK_HI or CHK_LO (registered alongside state).
- Latency: d_raw settles before posedge n and stays stable. d_clean changes after posedge n+STABLE_CYCLES+1, i.e. STABLE_CYCLES+2 edges including n. With the default (4), d_clean is visible after edge n+5.
- Rejection rule: a new level held for fewer than STABLE_CYCLES consecutive s samples never changes d_clean, rise or fall. A level held for exactly STABLE_CYCLES s samples is accepted.
- Counter: cnt never exceeds STABLE_CYCLES-1 and never wraps. CNT_W must hold STABLE_CYCLES-1.
- Simultaneous events: rst=1 overrides a qualifying edge on the same posedge. No pulse is emitted and d_clean=0.
- Reset mid-qualification: partial count is discarded. After rst deasserts, qualification restarts from STABLE_LO even if d_raw is held high.
- d_raw with X/Z after reset: outside scope. The bench drives only 0/1.

Test Plan:
- Reset: rst=1 for 2 cycles with d_raw=1 -> d_clean=0, rise=0, fall=0, busy=0, state STABLE_LO. After release, d_clean=1 and a single rise pulse occur on the 6th posedge counting the first post-release edge.
- Clean rising step (clk period 10, STABLE_CYCLES=4): d_raw 0->1 at t=102, held -> busy=1 from after edge t=125. d_clean=1 and rise=1 after edge t=155. rise=0 after edge t=165. fall never asserts.
- Bounce rejection: d_raw pulses high for 25 ns (3 samples), then low -> busy asserts then clears. d_clean stays 0, rise never asserts.
- Boundary acceptance: d_raw high for exactly 4 sampled edges, then low:
  - d_clean=1 with a single rise pulse.
  - Subsequent low qualifies after 4 more s samples, with a single fall pulse and d_clean=0.
- Reset mid-operation: d_raw goes high, then rst=1 on the edge where cnt==2 -> cnt=0, busy=0, no rise. With d_raw held high after release, d_clean rises STABLE_CYCLES+2 edges later.
- Integration: d_clean drives dflipflop.d -> Q follows d_clean one edge later, Qn=~Q. Q never toggles during 1-3 sample bounce bursts.
